// File: rtl/fractal_pkg.sv
// rtl/fractal_pkg.sv - shared constants and slot type for the fractal ring
//
// Purpose: Q4.28 fixed-point constants, the iteration limit, and the
//          per-slot bookkeeping record used around the fractal kernel ring.
// Ports:   none (package)

package fractal_pkg;

  // Q4.28 fixed point: 4 integer bits (sign included), 28 fraction bits
  localparam int unsigned FRAC_BITS = 28;
  localparam logic [31:0] ONE       = 32'h1000_0000;  // 1.0
  localparam logic [31:0] ESCAPE    = 32'h4000_0000;  // 4.0, |z|^2 bailout

  localparam int unsigned ITER_WIDTH = 8;
  localparam int unsigned MAX_ITER   = 255;

  localparam int unsigned SLOT_TAG_WIDTH = 16;

  // Sideband record that travels alongside one kernel pipeline slot
  typedef struct packed {
    logic                      valid;
    logic [SLOT_TAG_WIDTH-1:0] tag;
  } slot_t;

endpackage : fractal_pkg

// File: rtl/fractal_scheduler.sv
// rtl/fractal_scheduler.sv - ring controller around one fractal_kernel
//
// Purpose: Injects pixel seeds into free kernel slots, recirculates
//          unfinished pixels, and retires finished ones as (iter, tag)
//          results. Slot validity and tags live here; the kernel only
//          carries the numeric state.
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   in_valid/in_ready      seed handshake; in_cr, in_ci, in_tag seed data
//   res_valid/res_ready    result handshake; res_iter, res_tag result data
//   busy                   any slot occupied or result pending
//   k_*_in                 driven into the kernel this cycle
//   k_*_out                returned by the kernel PIPELINE_DEPTH cycles later

module fractal_scheduler
  import fractal_pkg::*;
#(
  parameter int unsigned PIPELINE_DEPTH = 9,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TAG_WIDTH      = SLOT_TAG_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,

  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_cr,
  input  logic [DATA_WIDTH-1:0] in_ci,
  input  logic [TAG_WIDTH-1:0]  in_tag,

  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ITER_WIDTH-1:0] res_iter,
  output logic [TAG_WIDTH-1:0]  res_tag,

  output logic                  busy,

  output logic                  k_inc_enabled,
  output logic [DATA_WIDTH-1:0] k_zr_in,
  output logic [DATA_WIDTH-1:0] k_zi_in,
  output logic [DATA_WIDTH-1:0] k_cr_in,
  output logic [DATA_WIDTH-1:0] k_ci_in,
  output logic [ITER_WIDTH-1:0] k_iter_in,
  output logic                  k_finished_in,

  input  logic [DATA_WIDTH-1:0] k_zr_out,
  input  logic [DATA_WIDTH-1:0] k_zi_out,
  input  logic [DATA_WIDTH-1:0] k_cr_out,
  input  logic [DATA_WIDTH-1:0] k_ci_out,
  input  logic [ITER_WIDTH-1:0] k_iter_out,
  input  logic                  k_finished_out
);

  // Slot sideband shift register, in lockstep with the kernel pipeline.
  // Index 0 is written this cycle; index PIPELINE_DEPTH-1 is the slot whose
  // kernel results are currently on k_*_out.
  logic [PIPELINE_DEPTH-1:0] slot_valid;
  logic [TAG_WIDTH-1:0]      slot_tag [PIPELINE_DEPTH];

  logic                 ret_valid;
  logic [TAG_WIDTH-1:0] ret_tag;
  logic                 out_free;
  logic                 do_recirc;
  logic                 do_retire;
  logic                 accept;
  logic                 new_valid;
  logic [TAG_WIDTH-1:0] new_tag;

  assign ret_valid = slot_valid[PIPELINE_DEPTH-1];
  assign ret_tag   = slot_tag[PIPELINE_DEPTH-1];

  // The result register can take a new value if it is empty or being
  // drained on this same edge.
  assign out_free = !res_valid || res_ready;

  // A finished pixel that cannot retire keeps circulating; the kernel
  // holds its iteration count because finished_in stays set.
  assign do_recirc = ret_valid && (!k_finished_out || !out_free);
  assign do_retire = ret_valid &&   k_finished_out &&  out_free;

  // The returning slot is reusable when it is empty or retiring now, so a
  // retire and an inject can share one cycle without a bubble. Only
  // registered state and res_ready feed this.
  assign in_ready = !do_recirc;
  assign accept   = in_ready && in_valid;

  assign k_inc_enabled = 1'b1;

  // Kernel input mux: recirculate, inject a fresh seed, or park an empty
  // slot as finished zeros so the kernel never iterates garbage.
  always_comb begin
    k_zr_in       = '0;
    k_zi_in       = '0;
    k_cr_in       = '0;
    k_ci_in       = '0;
    k_iter_in     = '0;
    k_finished_in = 1'b1;
    new_valid     = 1'b0;
    new_tag       = '0;
    if (do_recirc) begin
      k_zr_in       = k_zr_out;
      k_zi_in       = k_zi_out;
      k_cr_in       = k_cr_out;
      k_ci_in       = k_ci_out;
      k_iter_in     = k_iter_out;
      k_finished_in = k_finished_out;
      new_valid     = 1'b1;
      new_tag       = ret_tag;
    end else if (accept) begin
      k_cr_in       = in_cr;
      k_ci_in       = in_ci;
      k_finished_in = 1'b0;
      new_valid     = 1'b1;
      new_tag       = in_tag;
    end
  end

  // Slot sideband shift register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot_valid <= '0;
      for (int i = 0; i < int'(PIPELINE_DEPTH); i++) begin
        slot_tag[i] <= '0;
      end
    end else begin
      slot_valid <= {slot_valid[PIPELINE_DEPTH-2:0], new_valid};
      slot_tag[0] <= new_tag;
      for (int i = 1; i < int'(PIPELINE_DEPTH); i++) begin
        slot_tag[i] <= slot_tag[i-1];
      end
    end
  end

  // Result register: a retire reloads it even while the previous result is
  // being accepted; otherwise a handshake empties it. Data only changes on
  // a reload, and a reload only happens when out_free, so a stalled result
  // stays put.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      res_valid <= 1'b0;
      res_iter  <= '0;
      res_tag   <= '0;
    end else if (do_retire) begin
      res_valid <= 1'b1;
      res_iter  <= k_iter_out;
      res_tag   <= ret_tag;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  assign busy = (|slot_valid) || res_valid;

endmodule : fractal_scheduler

// File: tb/tb_fractal_scheduler.sv
// tb/tb_fractal_scheduler.sv - scoreboard bench for fractal_scheduler

module tb_fractal_scheduler;

  localparam int PD = 9;
  localparam int DW = 32;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_cr, in_ci;
  logic [TW-1:0] in_tag;
  logic          res_valid;
  logic          res_ready;
  logic [7:0]    res_iter;
  logic [TW-1:0] res_tag;
  logic          busy;
  logic          k_inc_enabled;
  logic [DW-1:0] k_zr_in, k_zi_in, k_cr_in, k_ci_in;
  logic [7:0]    k_iter_in;
  logic          k_finished_in;
  logic [DW-1:0] k_zr_out, k_zi_out, k_cr_out, k_ci_out;
  logic [7:0]    k_iter_out;
  logic          k_finished_out;

  fractal_scheduler #(.PIPELINE_DEPTH(PD), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cr(in_cr), .in_ci(in_ci), .in_tag(in_tag),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_iter(res_iter), .res_tag(res_tag),
    .busy(busy),
    .k_inc_enabled(k_inc_enabled),
    .k_zr_in(k_zr_in), .k_zi_in(k_zi_in), .k_cr_in(k_cr_in), .k_ci_in(k_ci_in),
    .k_iter_in(k_iter_in), .k_finished_in(k_finished_in),
    .k_zr_out(k_zr_out), .k_zi_out(k_zi_out), .k_cr_out(k_cr_out), .k_ci_out(k_ci_out),
    .k_iter_out(k_iter_out), .k_finished_out(k_finished_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural kernel (escape test on incoming z) --------
  typedef struct packed {
    logic [31:0] zr, zi, cr, ci;
    logic [7:0]  iter;
    logic        fin;
  } kst_t;

  function automatic kst_t kstep(input kst_t s, input logic inc);
    kst_t r;
    longint zr, zi, sr, si;
    r = s;
    if (!inc || s.fin) return r;
    zr = longint'($signed(s.zr));
    zi = longint'($signed(s.zi));
    sr = (zr * zr) >>> 28;
    si = (zi * zi) >>> 28;
    r.iter = s.iter + 8'd1;
    r.fin  = ((sr + si) > (longint'(4) <<< 28)) || (r.iter == 8'd255);
    r.zr   = 32'(sr - si + longint'($signed(s.cr)));
    r.zi   = 32'(((zr * zi) >>> 27) + longint'($signed(s.ci)));
    return r;
  endfunction

  kst_t kin;
  kst_t kpipe [PD];
  assign kin = {k_zr_in, k_zi_in, k_cr_in, k_ci_in, k_iter_in, k_finished_in};
  assign {k_zr_out, k_zi_out, k_cr_out, k_ci_out, k_iter_out, k_finished_out} = kpipe[PD-1];

  initial for (int i = 0; i < PD; i++) kpipe[i] = '0;

  always @(posedge clk) begin
    for (int i = PD - 1; i > 0; i--) kpipe[i] <= kpipe[i-1];
    kpipe[0] <= kstep(kin, k_inc_enabled);
  end

  // ---------------- reference: escape-time count from scratch -------------
  function automatic int ref_iter(input logic [31:0] cr, input logic [31:0] ci);
    longint a, b, sa, sb, c_r, c_i;
    a = 0; b = 0;
    c_r = longint'($signed(cr));
    c_i = longint'($signed(ci));
    for (int n = 1; n <= 255; n++) begin
      sa = (a * a) >>> 28;
      sb = (b * b) >>> 28;
      if (sa + sb > (longint'(4) <<< 28) || n == 255) return n;
      b = longint'($signed(32'(((a * b) >>> 27) + c_i)));
      a = longint'($signed(32'(sa - sb + c_r)));
    end
    return 255;
  endfunction

  // ---------------- scoreboard ---------------------------------------------
  typedef struct {
    logic [TW-1:0] tag;
    int            iter;
  } exp_t;

  exp_t exp_q[$];
  int   nchk = 0;
  int   npass = 0;

  task automatic chk(input string name, input bit ok, input longint act, input longint req);
    nchk++;
    if (ok) npass++;
    else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
                  name, act, act, req, req, cyc);
  endtask

  // res_ready modes: 0 always ready, 1 random, 2 stalled
  int rr_mode = 0;
  always @(negedge clk) begin
    case (rr_mode)
      0:       res_ready = 1'b1;
      1:       res_ready = ($urandom_range(0, 3) != 0);
      default: res_ready = 1'b0;
    endcase
  end

  // Monitor: pops matching tag on each handshake; checks hold while stalled
  bit         prev_stall = 0;
  logic [7:0] prev_iter;
  logic [TW-1:0] prev_tag;
  always @(negedge clk) begin
    #2;
    if (!resetn) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", res_valid == 1'b1, longint'(res_valid), 1);
        chk("hold_tag", res_tag == prev_tag, longint'(res_tag), longint'(prev_tag));
        chk("hold_iter", res_iter == prev_iter, longint'(res_iter), longint'(prev_iter));
      end
      if (res_valid && res_ready) begin
        int idx;
        idx = -1;
        foreach (exp_q[i]) if (idx < 0 && exp_q[i].tag == res_tag) idx = i;
        chk("result_tag_known", idx >= 0, longint'(res_tag), longint'(res_tag) + 65536);
        if (idx >= 0) begin
          chk("result_iter", int'(res_iter) == exp_q[idx].iter, longint'(res_iter),
              longint'(exp_q[idx].iter));
          exp_q.delete(idx);
        end
      end
      prev_stall = res_valid && !res_ready;
      prev_iter  = res_iter;
      prev_tag   = res_tag;
    end
  end

  // ---------------- stimulus tasks ----------------------------------------
  // Offers one seed until accepted; acc is the cycle in which it was taken.
  task automatic send(input logic [31:0] cr, input logic [31:0] ci,
                      input logic [TW-1:0] tag, output int acc);
    bit done;
    int w;
    done = 0; w = 0; acc = -1;
    while (!done) begin
      @(negedge clk);
      in_valid = 1'b1; in_cr = cr; in_ci = ci; in_tag = tag;
      #1;
      if (in_ready) begin
        done = 1;
        acc  = cyc;
      end
      @(posedge clk);
      if (done) exp_q.push_back('{tag: tag, iter: ref_iter(cr, ci)});
      w++;
      if (!done && w > 20000) begin
        chk("send_timeout", 1'b0, longint'(w), 20000);
        done = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    int w;
    w = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while ((busy || exp_q.size() != 0) && w < budget) begin
      @(negedge clk);
      w++;
    end
    #3;
    chk("drain", !busy && exp_q.size() == 0, longint'(exp_q.size()), 0);
  endtask

  localparam logic [31:0] C_TWO = 32'h2000_0000;

  int acc_a [PD+2];
  int acc0;
  int t;

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_cr = '0; in_ci = '0; in_tag = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready == 1'b1, longint'(in_ready), 1);
    chk("rst_res_valid", res_valid == 1'b0, longint'(res_valid), 0);
    chk("rst_busy", busy == 1'b0, longint'(busy), 0);
    chk("rst_res_iter", res_iter == 8'd0, longint'(res_iter), 0);
    chk("rst_res_tag", res_tag == '0, longint'(res_tag), 0);
    chk("k_inc_enabled", k_inc_enabled == 1'b1, longint'(k_inc_enabled), 1);
    @(negedge clk);
    resetn = 1'b1;

    // c = 2.0: three ring passes, result visible 3*PD+1 cycles after injection
    send(C_TWO, 32'h0, 16'd5, acc0);
    t = 0;
    @(negedge clk); in_valid = 1'b0;
    while (!res_valid && t < 200) begin @(negedge clk); t++; end
    chk("latency_c2", cyc - acc0 == 3 * PD + 1, longint'(cyc - acc0), 3 * PD + 1);
    chk("iter_c2", res_iter == 8'd3 && res_tag == 16'd5, longint'({res_tag, res_iter}),
        longint'({16'd5, 8'd3}));
    wait_idle(500);

    // c = 0: never escapes, retires at the iteration limit
    send(32'h0, 32'h0, 16'd6, acc0);
    wait_idle(4000);

    // PD+2 back-to-back seeds: ring fills, then reuses retiring slots
    for (int i = 0; i < PD + 2; i++) send(C_TWO, 32'h0, TW'(100 + i), acc_a[i]);
    for (int i = 1; i < PD + 2; i++) begin
      int req;
      req = (i < PD) ? i : 3 * PD + (i - PD);
      chk("accept_cycle", acc_a[i] - acc_a[0] == req, longint'(acc_a[i] - acc_a[0]), req);
    end
    wait_idle(500);

    // Backpressure: three pixels finish while the output is stalled
    rr_mode = 2;
    for (int i = 0; i < 3; i++) send(C_TWO, 32'h0, TW'(200 + i), acc0);
    idle(60);
    #3;
    chk("bp_head_valid", res_valid == 1'b1, longint'(res_valid), 1);
    chk("bp_head_tag", res_tag == 16'd200, longint'(res_tag), 200);
    chk("bp_head_iter", res_iter == 8'd3, longint'(res_iter), 3);
    chk("bp_busy", busy == 1'b1, longint'(busy), 1);
    rr_mode = 0;
    wait_idle(500);

    // Randomised seeds with random gaps and random output stalls
    rr_mode = 1;
    for (int i = 0; i < 30; i++) begin
      logic [31:0] cr, ci;
      cr = 32'($signed($urandom) >>> 2);
      ci = 32'($signed($urandom) >>> 2);
      send(cr, ci, TW'(1000 + i), acc0);
      idle($urandom_range(0, 3));
    end
    rr_mode = 0;
    wait_idle(20000);

    // Reset with five pixels in flight: everything is discarded at once
    for (int i = 0; i < 5; i++) send(32'h0, 32'h0, TW'(300 + i), acc0);
    idle(20);
    resetn = 1'b0;
    #1;
    chk("mid_rst_res_valid", res_valid == 1'b0, longint'(res_valid), 0);
    chk("mid_rst_busy", busy == 1'b0, longint'(busy), 0);
    exp_q.delete();
    idle(3);
    resetn = 1'b1;
    idle(300);
    #3;
    chk("post_rst_busy", busy == 1'b0, longint'(busy), 0);
    chk("post_rst_res_valid", res_valid == 1'b0, longint'(res_valid), 0);
    send(C_TWO, 32'h0, 16'd7, acc0);
    wait_idle(500);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule : tb_fractal_scheduler
